conv_window_gen: RTL
====================

// Module: conv_window_gen
// PURPOSE
//  Upstream feeder for the 3x3 convolution stage. It takes a row-major pixel stream, one pixel per
//  transfer, and buffers R-1 image rows. For every valid RxC neighbourhood it emits one packed window.
//  The window has the same flat layout the conv A/B operand expects.
//  A valid/ready handshake on the output lets the multi-cycle convolution stage stall the stream.
// PARAMETERS
//  In_d_W  8   pixel width (bits)
//  R       3   window rows
//  C       3   window cols
//  IMG_W   28  image width in pixels (must be >= C)
//  IMG_H   28  image height in pixels (must be >= R)
// PORTS
//  clk        in   1               single clock; all logic on rising edge
//  rst        in   1               synchronous reset, active-low (0 = reset)
//  pix_valid  in   1               pix_in holds a pixel
//  pix_ready  out  1               block can accept a pixel this cycle
//  pix_in     in   In_d_W          pixel, row-major, top-left first
//  win_valid  out  1               win holds a complete window
//  win_ready  in   1               consumer takes the window this cycle
//  win        out  R*C*In_d_W      window; element (r,c) at [(r*C+c)*In_d_W +: In_d_W], r=0 oldest row, c=0 leftmost
//  frame_done out  1               1-cycle pulse: last pixel of the frame accepted
//  win_row    out  $clog2(IMG_H)   top row of the window (CONV_WIN_POS_EN only)
//  win_col    out  $clog2(IMG_W)   left column of the window (CONV_WIN_POS_EN only)
// BEHAVIOUR
//  - Pixel transfer: pix_valid && pix_ready. Window transfer: win_valid && win_ready.
//  - pix_ready = !win_valid || win_ready. The output register may be refilled in the same cycle it is drained.
//  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the accepted pixel.
//    - col wraps to 0 and row increments after col = IMG_W-1.
//    - Both wrap to 0 after the last pixel of the frame; frame_done pulses in that cycle.
//  - Line buffers: R-1 shift rows of depth IMG_W, advanced only on a pixel transfer.
//    Together with a RxC shift window they give the current neighbourhood.
//  - A window is emitted when the accepted pixel has row >= R-1 && col >= C-1.
//    - Windows straddling a row boundary are never emitted.
//    - Window count per frame = (IMG_H-R+1)*(IMG_W-C+1); 676 at the defaults.
//  - Latency: win/win_valid are registered; win_valid rises the cycle after the completing pixel transfer.
//    win is stable while win_valid && !win_ready.
//  - FSM, encoded in conv_pkg:
//    - FILL: row < R-1, no windows. Goes to RUN when a pixel with row = R-1 is accepted.
//    - RUN: windows are produced as defined above.
//    - STALL: win_valid && !win_ready. pix_ready = 0. Returns to RUN on win_ready.
//    - Back to FILL in the same cycle frame_done pulses.
//  - Simultaneous window drain and pixel accept in STALL: the drained window leaves.
//    If that pixel completes a new window, the new window is loaded next cycle and no bubble is inserted.
//  - Reset (rst=0), also mid-frame:
//    - col, row and FSM go to 0/FILL; win_valid=0, win=0, frame_done=0; pix_ready=1 the cycle after reset.
//    - Line-buffer contents are not reset. Stale data is never emitted because the counters gate validity.
//  - The next frame may follow the last pixel with no gap.
// CONFIGURATION
//  - CONV_WIN_POS_EN defined: win_row/win_col ports exist.
//    - They are registered together with win, reset to 0, and hold the top-left coordinate: row-R+1, col-C+1.
//  - CONV_WIN_POS_EN undefined: both ports and their registers are omitted; all other behaviour is identical.
// STRUCTURE
//  - conv_pkg holds:
//    - FSM state typedef (FILL, RUN, STALL)
//    - window index helper function (r,c) -> bit offset
//    - default width constants
//  - Sub-module conv_line_buf: one IMG_W-deep, In_d_W-wide shift row with shift enable.
//    It is instantiated R-1 times in a generate loop.
// TESTING
//  1. IMG_W=IMG_H=4, pixels 1..16, win_ready=1 -> 4 windows.
//     First window elements (r,c) row-major: {1,2,3,5,6,7,9,10,11}. Last: {6,7,8,10,11,12,14,15,16}.
//     frame_done pulses on pixel 16.
//  2. Same stream, win_ready=0 for 5 cycles after the first win_valid.
//     -> win is held constant, pix_ready=0, no pixel is lost, all 4 windows are correct.
//  3. Defaults, 2 back-to-back frames, random pix_valid gaps.
//     -> 676 windows per frame, matching a software reference; no window mixes data from two frames.
//  4. rst=0 for 1 cycle after pixel 10 of a 4x4 frame, then a full new frame 1..16.
//     -> no window before row 2 of the new frame; the 4 windows equal test 1.
//  5. CONV_WIN_POS_EN defined, 4x4 frame.
//     -> (win_row,win_col) = (0,0), (0,1), (1,0), (1,1), in order.
//  6. Consumer asserts win_ready in the same cycle a completing pixel arrives in STALL.
//     -> the next window appears the following cycle, with no dropped or duplicated window.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared FSM type, default geometry and window-layout helper for conv_window_gen.
package conv_pkg;

    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_R     = 3;
    localparam int unsigned DEF_C     = 3;
    localparam int unsigned DEF_IMG_W = 28;
    localparam int unsigned DEF_IMG_H = 28;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } conv_state_t;

    // Bit offset of window element (r,c) in the flat conv operand layout.
    function automatic int unsigned win_off(input int unsigned r, input int unsigned c,
                                            input int unsigned cols, input int unsigned width);
        return (r * cols + c) * width;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image-row delay line: the tap shows the pixel pushed DEPTH enables ago.
module conv_line_buf #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 28
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] pix,
    output logic [W-1:0] tap
);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately unreset; the window generator's counters gate validity.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= pix;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Turns a row-major pixel stream into RxC windows for the conv stage.
// Optional CONV_WIN_POS_EN adds registered win_row/win_col (window top-left).
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned In_d_W = DEF_PIX_W,
    parameter int unsigned R      = DEF_R,
    parameter int unsigned C      = DEF_C,
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [In_d_W-1:0]         pix_in,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [R*C*In_d_W-1:0]     win,
    output logic                      frame_done
`ifdef CONV_WIN_POS_EN
    ,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col
`endif
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WIN_W = R * C * In_d_W;

    conv_state_t          state;
    conv_state_t          next_state;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic                 pix_xfer;
    logic                 col_last;
    logic                 row_last;
    logic                 emit;
    logic                 frame_last;

    logic [In_d_W-1:0]    lb_in   [R-1];
    logic [In_d_W-1:0]    lb_out  [R-1];
    logic [In_d_W-1:0]    new_col [R];
    logic [In_d_W-1:0]    sw      [R][C];
    logic [In_d_W-1:0]    sw_next [R][C];
    logic [WIN_W-1:0]     win_next;

    // Line buffers chained so buffer i delays the stream by i+1 rows.
    for (genvar i = 0; i < int'(R) - 1; i++) begin : g_lb
        if (i == 0) begin : g_head
            assign lb_in[i] = pix_in;
        end else begin : g_tail
            assign lb_in[i] = lb_out[i-1];
        end
        conv_line_buf #(
            .W     (In_d_W),
            .DEPTH (IMG_W)
        ) u_lb (
            .clk (clk),
            .en  (pix_xfer),
            .pix (lb_in[i]),
            .tap (lb_out[i])
        );
    end

    // Column entering the window: newest row at the bottom (r = R-1).
    always_comb begin
        new_col[R-1] = pix_in;
        for (int unsigned i = 0; i + 1 < R; i++) begin
            new_col[R-2-i] = lb_out[i];
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < R; r++) begin
            for (int unsigned c = 0; c + 1 < C; c++) begin
                sw_next[r][c] = sw[r][c+1];
            end
            sw_next[r][C-1] = new_col[r];
        end
    end

    always_comb begin
        win_next = '0;
        for (int unsigned r = 0; r < R; r++) begin
            for (int unsigned c = 0; c < C; c++) begin
                win_next[win_off(r, c, C, In_d_W) +: In_d_W] = sw_next[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_xfer) begin
            sw <= sw_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; the frame's last pixel always returns to FILL.
    always_comb begin
        next_state = state;
        unique case (state)
            FILL:    if (pix_xfer && row == ROW_W'(R - 1)) next_state = RUN;
            RUN:     if (win_valid && !win_ready) next_state = STALL;
            STALL:   if (win_ready) next_state = RUN;
            default: next_state = FILL;
        endcase
        if (frame_last) begin
            next_state = FILL;
        end
    end

    // FSM outputs: handshake and window-completion decode.
    always_comb begin
        pix_ready  = !win_valid || win_ready;
        pix_xfer   = pix_valid && pix_ready && rst;
        col_last   = (col == COL_W'(IMG_W - 1));
        row_last   = (row == ROW_W'(IMG_H - 1));
        emit       = pix_xfer && (row >= ROW_W'(R - 1)) && (col >= COL_W'(C - 1));
        frame_last = pix_xfer && col_last && row_last;
    end

    // Position counters and the registered window output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win        <= '0;
            frame_done <= 1'b0;
`ifdef CONV_WIN_POS_EN
            win_row    <= '0;
            win_col    <= '0;
`endif
        end else begin
            frame_done <= frame_last;
            if (pix_xfer) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (emit) begin
                win_valid <= 1'b1;
                win       <= win_next;
`ifdef CONV_WIN_POS_EN
                win_row   <= row - ROW_W'(R - 1);
                win_col   <= col - COL_W'(C - 1);
`endif
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
